// File: rtl/uart_autobaud.sv
// UART auto-baud detector: measures the bit time of a 0x55 sync byte
// and publishes it as a clocks-per-bit divisor.
module uart_autobaud #(
    parameter int                   CNT_WIDTH = 16,
    parameter int                   FILT_LEN  = 3,
    parameter int                   MIN_DIV   = 8,
    parameter logic [CNT_WIDTH-1:0] DEF_DIV   = 16'd868
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [CNT_WIDTH-1:0] div,
    output logic                 div_vld
);

    localparam int SW = CNT_WIDTH + 3;
    localparam logic [CNT_WIDTH-1:0] CMAX = '1;
    localparam logic [CNT_WIDTH-1:0] ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ARMED, MEASURE, STOP_CHK} state_e;

    state_e state_q, state_d;

    logic                 s1_q, s2_q;
    logic [FILT_LEN-1:0]  hist_q;
    logic                 filt_q, filt_d, prev_q;
    logic                 fall, rise;

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, i1_q, i1_d, div_q, div_d;
    logic [SW-1:0]        sum_q, sum_d;
    logic [1:0]           nfall_q, nfall_d;
    logic                 vld_q, vld_d, done_q, done_d, err_q, err_d;

    logic [CNT_WIDTH-1:0] ival, dev, half, eighth;
    logic [SW-1:0]        d_full;
    logic                 sat, in_tol, low_ok, d_ok;

    // Filtered line only moves once the whole history window agrees
    always_comb begin
        filt_d = filt_q;
        if (&hist_q)
            filt_d = 1'b1;
        else if (~|hist_q)
            filt_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            hist_q <= '1;
            filt_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            s1_q   <= rx;
            s2_q   <= s1_q;
            hist_q <= {hist_q[FILT_LEN-2:0], s2_q};
            filt_q <= filt_d;
            prev_q <= filt_q;
        end
    end

    assign fall = prev_q & ~filt_q;
    assign rise = ~prev_q & filt_q;

    assign sat    = (cnt_q == CMAX);
    assign ival   = cnt_q + ONE;
    assign dev    = (ival >= i1_q) ? ival - i1_q : i1_q - ival;
    assign in_tol = (dev <= (i1_q >> 2));
    assign half   = i1_q >> 1;
    assign eighth = i1_q >> 3;
    assign low_ok = (ival >= half - eighth) && (ival <= half + eighth);
    assign d_full = (sum_q + {{(SW-3){1'b0}}, 3'd4}) >> 3;
    assign d_ok   = (d_full[SW-1:CNT_WIDTH] == '0) && (d_full >= SW'(MIN_DIV));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (start) state_d = ARMED;
            ARMED:    if (fall) state_d = MEASURE;
            MEASURE: begin
                if (sat)
                    state_d = IDLE;
                else if (fall) begin
                    if (nfall_q != 2'd0 && !in_tol)
                        state_d = IDLE;
                    else if (nfall_q == 2'd3)
                        state_d = STOP_CHK;
                end
            end
            STOP_CHK: if (sat || rise) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        done_d  = 1'b0;
        err_d   = 1'b0;
        div_d   = div_q;
        vld_d   = vld_q;
        cnt_d   = cnt_q;
        i1_d    = i1_q;
        sum_d   = sum_q;
        nfall_d = nfall_q;
        unique case (state_q)
            ARMED: begin
                if (fall) begin
                    cnt_d   = '0;
                    sum_d   = '0;
                    nfall_d = 2'd0;
                end
            end
            MEASURE: begin
                if (sat)
                    err_d = 1'b1;
                else if (fall) begin
                    cnt_d   = '0;
                    nfall_d = nfall_q + 2'd1;
                    sum_d   = sum_q + {3'b000, ival};
                    if (nfall_q == 2'd0)
                        i1_d = ival;
                    else if (!in_tol)
                        err_d = 1'b1;
                end else
                    cnt_d = cnt_q + ONE;
            end
            STOP_CHK: begin
                if (sat)
                    err_d = 1'b1;
                else if (rise) begin
                    if (low_ok && d_ok) begin
                        done_d = 1'b1;
                        div_d  = d_full[CNT_WIDTH-1:0];
                        vld_d  = 1'b1;
                    end else
                        err_d = 1'b1;
                end else
                    cnt_d = cnt_q + ONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            i1_q    <= '0;
            sum_q   <= '0;
            nfall_q <= 2'd0;
            div_q   <= DEF_DIV;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            i1_q    <= i1_d;
            sum_q   <= sum_d;
            nfall_q <= nfall_d;
            div_q   <= div_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign err     = err_q;
    assign div     = div_q;
    assign div_vld = vld_q;

endmodule

// File: doc/uart_autobaud.md
UART_AUTOBAUD -- requirements
Module: uart_autobaud

Interface
REQ-001 Parameter CNT_WIDTH, default 16, sets the width of the per-bit divisor and of the interval counters.
REQ-002 Parameter FILT_LEN, default 3, sets the number of consecutive equal synchronized samples required to change the filtered line.
REQ-003 Parameter MIN_DIV, default 8, sets the smallest legal divisor, in clocks per bit.
REQ-004 Parameter DEF_DIV, default 16'd868, sets the divisor value loaded at reset.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-006 clk  input  1  system clock; all state changes on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 rx  input  1  raw UART line, asynchronous to clk, idle high.
REQ-009 start  input  1  one-cycle pulse that arms a measurement.
REQ-010 busy  output  1  high while the state is not IDLE.
REQ-011 done  output  1  one-cycle pulse when a measurement succeeds.
REQ-012 err  output  1  one-cycle pulse when a measurement fails.
REQ-013 div  output  CNT_WIDTH  measured clocks per bit, consumed by uart_rx/uart_tx.
REQ-014 div_vld  output  1  high once div holds a measured value.

Function
REQ-015 rx SHALL pass through a 2-flop synchronizer, then through a filter whose output takes value v only after FILT_LEN consecutive synchronized samples equal v.
REQ-016 The edge detector SHALL flag falling and rising edges of the filtered line, one cycle after the filter changes.
REQ-017 The state machine SHALL have four states: IDLE, ARMED, MEASURE and STOP_CHK.
REQ-018 In IDLE, start SHALL move the state to ARMED; start in any other state SHALL be ignored.
REQ-019 In ARMED, the first falling edge SHALL clear the interval counter and move the state to MEASURE.
REQ-020 If the line is low when the block is armed, measurement SHALL begin only after a subsequent high-to-low transition.
REQ-021 The expected character is sync byte 0x55, which gives five falling edges spaced two bit-times apart.
REQ-022 In MEASURE, the block SHALL count clocks between successive falling edges as intervals I1..I4.
REQ-023 In MEASURE, the block SHALL accumulate a running sum S of width CNT_WIDTH+3.
REQ-024 Each Ik (k=2..4) SHALL satisfy |Ik-I1| <= I1>>2; a violation SHALL raise err and return the state to IDLE.
REQ-025 After the 5th falling edge, the state SHALL move to STOP_CHK.
REQ-026 In STOP_CHK, the first rising edge SHALL compute D=(S+4)>>3.
REQ-027 If D>=MIN_DIV and D<2^CNT_WIDTH, the block SHALL load div<=D, set div_vld=1 and pulse done on the next cycle, then return to IDLE.
REQ-028 If D is out of range, the block SHALL pulse err and leave div and div_vld unchanged.
REQ-029 The interval counter SHALL saturate at 2^CNT_WIDTH-1 in MEASURE and STOP_CHK.
REQ-030 Reaching saturation SHALL pulse err and return the state to IDLE (timeout).
REQ-031 In STOP_CHK, the low-phase length SHALL also be checked against I1>>1 ± I1>>3; a mismatch SHALL pulse err.
REQ-032 done and err SHALL never be high in the same cycle.
REQ-033 div SHALL change only in the cycle in which done is asserted.
REQ-034 div SHALL hold its value across failed measurements.

Reset
REQ-035 On rst, state SHALL be IDLE, busy=0, done=0, err=0, div=DEF_DIV and div_vld=0.
REQ-036 On rst, synchronizer and filter state SHALL be set to 1, and all counters to 0.
REQ-037 rst asserted mid-measurement SHALL abort immediately, with no done or err pulse.

Verification
REQ-038 Arm, then send 0x55 at 100 clk/bit -> done pulse, div=100, div_vld=1, busy low next cycle.
REQ-039 Send 0x55 with each bit edge jittered ±10 clk at 100 clk/bit -> done, div within 99..101.
REQ-040 Send 0x57 at 100 clk/bit (I1=400, I2=200) -> err pulse at the 3rd falling edge; div keeps its previous value.
REQ-041 With CNT_WIDTH=12, send 0x00 then hold the line high -> err at interval count 4095; div_vld unchanged.
REQ-042 With FILT_LEN=3, inject a 2-clk low glitch while ARMED -> no state change; a following valid 0x55 gives a correct done.
REQ-043 Assert rst during MEASURE -> busy=0, div=DEF_DIV, div_vld=0 immediately; no done or err pulse.
